// File: rtl/act_skew_feeder.sv
// Activation skew feeder: buffers activation vectors in a small FIFO and
// injects them into the left edge of the MAC array, delaying row r by r
// cycles so activations meet the weights on the diagonal.
module act_skew_feeder #(
    parameter int A_BITWIDTH = 16,
    parameter int ROWS       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ROWS*A_BITWIDTH-1:0] vec_in,
    input  logic                       vec_valid,
    output logic                       vec_ready,
    input  logic                       start,
    input  logic [LEN_W-1:0]           num_vec,
    output logic [ROWS*A_BITWIDTH-1:0] A_out,
    output logic [ROWS-1:0]            A_en,
    output logic                       busy,
    output logic                       done
);

    localparam int VW = ROWS * A_BITWIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = A_BITWIDTH + 1;   // one skew stage: {en, data}

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    logic [VW-1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [VW-1:0]    pop_data;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [DW-1:0]    drain_cnt;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    // Ready comes from the registered count only, and is held low in reset.
    assign vec_ready = rst & ~full;
    assign push      = vec_valid & vec_ready;
    assign pop       = (state == STREAM) & ~empty;
    // Read is combinational so a popped vector enters stage 0 on the same edge.
    assign pop_data  = mem[rd_ptr];

    // FIFO storage write port; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= vec_in;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth makes pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Command sequencer with registered busy/done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_vec != '0) begin
                            remaining <= num_vec;
                            state     <= STREAM;
                            busy      <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (pop) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            if (ROWS == 1) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state     <= DRAIN;
                                drain_cnt <= DW'(ROWS - 1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    // Leave when the count reaches zero so DONE lines up with
                    // the last element arriving on the bottom row.
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt == DW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-row skew: row gi is a (gi+1)-stage shift register of {en, data}.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic [SW-1:0]          stage0;
            logic [(gi+1)*SW-1:0]   sr;

            assign stage0 = pop ? {1'b1, pop_data[gi*A_BITWIDTH +: A_BITWIDTH]} : '0;

            if (gi == 0) begin : g_first
                // Single stage: load the FIFO head or a bubble every cycle.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) sr <= '0;
                    else      sr <= stage0;
                end
            end else begin : g_deep
                // Shift toward the output, inserting the new stage at the bottom.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) sr <= '0;
                    else      sr <= {sr[gi*SW-1:0], stage0};
                end
            end

            assign A_en[gi]                           = sr[gi*SW + A_BITWIDTH];
            assign A_out[gi*A_BITWIDTH +: A_BITWIDTH] = sr[gi*SW +: A_BITWIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_act_skew_feeder.sv
// Bench for act_skew_feeder: directed vectors, scoreboard queue of pushed
// vectors, and a separate monitor that checks every row every cycle.
module tb_act_skew_feeder;

    localparam int W  = 16;
    localparam int R  = 4;
    localparam int D  = 8;
    localparam int L  = 8;
    localparam int VW = R * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [VW-1:0] vec_in = '0;
    logic          vec_valid = 1'b0;
    logic          vec_ready;
    logic          start = 1'b0;
    logic [L-1:0]  num_vec = '0;
    logic [VW-1:0] A_out;
    logic [R-1:0]  A_en;
    logic          busy;
    logic          done;

    act_skew_feeder #(.A_BITWIDTH(W), .ROWS(R), .FIFO_DEPTH(D), .LEN_W(L)) dut (
        .clk(clk), .rst(rst), .vec_in(vec_in), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .start(start), .num_vec(num_vec),
        .A_out(A_out), .A_en(A_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [VW-1:0] exp_q[$];
    int            idx[R];
    int            base = 0;
    int            arr0[256];
    int            n_pushed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] mk(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Monitor: each row must present the pushed vectors in order, row r
    // exactly r cycles after row 0, and zero data on bubbles.
    initial begin
        logic [VW-1:0] ev;
        for (int r = 0; r < R; r++) idx[r] = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                base = base + exp_q.size();
                exp_q.delete();
                for (int r = 0; r < R; r++) idx[r] = base;
            end else begin
                for (int r = 0; r < R; r++) begin
                    if (A_en[r]) begin
                        if (idx[r] - base >= exp_q.size()) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL row%0d_spurious: got A_en=1 data 'h%0h expected no activation (cycle %0d)",
                                     r, A_out[r*W +: W], cyc);
                        end else begin
                            ev = exp_q[idx[r] - base];
                            check($sformatf("row%0d_data_v%0d", r, idx[r]), A_out[r*W +: W], ev[r*W +: W]);
                            if (r == 0) arr0[idx[0] % 256] = cyc;
                            else check($sformatf("row%0d_skew_v%0d", r, idx[r]), cyc - arr0[idx[r] % 256], r);
                            idx[r]++;
                        end
                    end else begin
                        check($sformatf("row%0d_bubble_zero", r), A_out[r*W +: W], 0);
                    end
                end
                while (exp_q.size() > 0 && idx[R-1] > base) begin
                    void'(exp_q.pop_front());
                    base++;
                end
            end
        end
    end

    task automatic push(input logic [VW-1:0] v);
        int i = 0;
        @(negedge clk);
        vec_valid = 1'b1;
        vec_in    = v;
        while (!vec_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!vec_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: got vec_ready=0 expected 1 within 50 cycles");
        end else begin
            exp_q.push_back(v);
            $display("push v%0d = 'h%0h at cycle %0d", n_pushed, v, cyc);
            n_pushed++;
        end
        @(posedge clk);
        #1 vec_valid = 1'b0;
    endtask

    task automatic do_start(input int n, output int t);
        @(negedge clk);
        start   = 1'b1;
        num_vec = n[L-1:0];
        @(posedge clk);
        #1 start = 1'b0;
        t = cyc;
        $display("start num_vec=%0d, first stream cycle %0d", n, t);
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        int dc = -1;
        for (int i = 0; i < 200 && dc < 0; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                check({name, "_busy_in_done"}, busy, 0);
            end
        end
        $display("%s: done at cycle %0d (expected %0d)", name, dc, exp_cyc);
        check({name, "_done_cycle"}, dc, exp_cyc);
        @(negedge clk);
        check({name, "_done_one_pulse"}, done, 0);
        check({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int t, t2, k, extra;
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, k, extra, w;
        // Reset state
        #1 rst = 1'b0;
        #1;
        check("rst_A_en", A_en, 0);
        check("rst_A_out", A_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec_ready", vec_ready, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("post_rst_vec_ready", vec_ready, 1);

        // Basic skew
        k = n_pushed;
        push(mk(1, 2, 3, 4));
        push(mk(5, 6, 7, 8));
        do_start(2, t);
        @(negedge clk);
        check("basic_busy", busy, 1);
        wait_done("basic", t + 5);
        check("basic_row0_first", arr0[k % 256], t + 1);
        check("basic_row0_second", arr0[(k + 1) % 256], t + 2);

        // Underflow bubble
        k = n_pushed;
        push(mk(16'h0101, 16'h0202, 16'h0303, 16'h0404));
        do_start(2, t);
        repeat (2) @(posedge clk);
        push(mk(16'h0505, 16'h0606, 16'h0707, 16'h0808));
        wait_done("bubble", t + 7);
        check("bubble_row0_first", arr0[k % 256], t + 1);
        check("bubble_row0_second", arr0[(k + 1) % 256], t + 4);

        // FIFO full and wrap
        for (int i = 0; i < 8; i++) push(mk(W'(16*i+1), W'(16*i+2), W'(16*i+3), W'(16*i+4)));
        @(negedge clk);
        check("full_vec_ready", vec_ready, 0);
        vec_valid = 1'b1;
        vec_in    = mk(16'hdead, 16'hdead, 16'hdead, 16'hdead);
        @(posedge clk);
        #1 vec_valid = 1'b0;
        do_start(10, t);
        push(mk(16'h0a01, 16'h0a02, 16'h0a03, 16'h0a04));
        push(mk(16'h0b01, 16'h0b02, 16'h0b03, 16'h0b04));
        wait_done("full_wrap", t + 13);

        // Zero-length start
        do_start(0, t);
        wait_done("zero_len", t);

        // Start ignored while streaming
        for (int i = 0; i < 3; i++) push(mk(W'(100+i), W'(200+i), W'(300+i), W'(400+i)));
        do_start(3, t);
        @(negedge clk);
        check("ignored_busy", busy, 1);
        start   = 1'b1;
        num_vec = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ignored_start", t + 6);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("ignored_extra_done", extra, 0);

        // Async reset mid-drain; the third vector must be discarded
        push(mk(16'h1111, 16'h1112, 16'h1113, 16'h1114));
        push(mk(16'h2221, 16'h2222, 16'h2223, 16'h2224));
        push(mk(16'h3331, 16'h3332, 16'h3333, 16'h3334));
        do_start(2, t);
        w = 0;
        while (cyc != t + 3 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("arst_reach_drain", cyc, t + 3);
        check("arst_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        $display("async reset asserted at cycle %0d", cyc);
        check("arst_A_en", A_en, 0);
        check("arst_A_out", A_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_vec_ready", vec_ready, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("arst_release_ready", vec_ready, 1);
        check("arst_release_busy", busy, 0);

        // Signed pass-through after reset (also proves the FIFO was emptied)
        k = n_pushed;
        push(mk(16'h0011, 16'h0022, 16'h8001, 16'h7fff));
        do_start(1, t2);
        wait_done("signed", t2 + 4);
        check("signed_row0_first", arr0[k % 256], t2 + 1);

        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
